nl2_dbank_scrub_queue: RTL and testbench
========================================

// Module: nl2_dbank_scrub_queue
// PURPOSE
// Consumes scrub requests (single-bit-error reads) from the dbank buffer-control stage.
// Dedups and queues them, then issues one scrub command at a time to the dbank arbiter.
// Holds do_scrub high for the duration of each issued scrub, until write completion.
// Keeps saturating SBE/DBE event counters and sticky overflow/timeout flags for CSRs.
// PARAMETERS
// N_SRAM          4    SRAM select width (one-hot)
// BLOCK_ADDR_SIZE 10   block address width
// DEPTH           4    queue entries; power of two, 2..16
// CNT_W           16   error counter width
// TIMEOUT_CYC     255  max cycles in WAIT before abort; 0 disables timeout
// PORTS
// dbank_ctrl_clk       in  1         clock
// rst_a_n              in  1         reset, asynchronous, active-low
// scrub_en             in  1         CSR: permit issuing scrubs
// scrub_req_valid      in  1         scrub request (rdata_out_scrub_req)
// scrub_req_sram_sel   in  N_SRAM    request SRAM select
// scrub_req_block_addr in  BLOCK_ADDR_SIZE  request block address
// rmw_sbe              in  1         RMW read single-bit error
// rmw_dbe              in  1         RMW read double/unknown error
// rd_dbe               in  1         read-path DBE (rdata_out_valid & rdata_out_dbe)
// scrub_cmd_valid      out 1         scrub command valid
// scrub_cmd_accept     in  1         arbiter accepts command
// scrub_cmd_sram_sel   out N_SRAM    command SRAM select
// scrub_cmd_block_addr out BLOCK_ADDR_SIZE  command block address
// scrub_done           in  1         scrub write completed (wr_done of scrub)
// do_scrub             out 1         scrub in flight
// sbe_cnt              out CNT_W     saturating SBE count
// dbe_cnt              out CNT_W     saturating DBE count
// cnt_clr              in  1         clear both counters
// ovf_sticky           out 1         request dropped because queue full
// tmo_sticky           out 1         WAIT timeout occurred
// flag_clr             in  1         clear both sticky flags
// scrub_idle           out 1         queue empty, FSM IDLE
// BEHAVIOUR
// - Reset: all outputs 0 except scrub_idle=1; queue empty; FSM IDLE.
// - Push: scrub_req_valid with {sel,addr} not matching any valid entry or the in-flight
//   entry -> written at tail. Duplicate -> dropped silently. No overflow.
// - Full with non-duplicate request -> dropped, ovf_sticky set.
// - Full is evaluated after a same-cycle pop, so push+pop on a full queue is accepted.
// - Pointers wrap modulo DEPTH; occupancy counter is $clog2(DEPTH)+1 bits.
// - FSM: IDLE -> REQ when queue non-empty & scrub_en.
//   REQ: scrub_cmd_valid=1, payload=head; payload stable until accept.
//   REQ -> WAIT on scrub_cmd_accept; head popped and copied to in-flight reg.
//   WAIT: do_scrub=1. WAIT -> IDLE on scrub_done, or on timeout.
//   Timeout: TIMEOUT_CYC cycles in WAIT without done -> IDLE, tmo_sticky set,
//   in-flight entry discarded.
//   scrub_done outside WAIT is ignored.
// - Latency: push at edge k -> REQ at edge k+1 -> scrub_cmd_valid from k+1.
//   After done, next REQ no earlier than 1 cycle later (via IDLE).
// - scrub_en low: IDLE holds; REQ/WAIT complete normally; the queue still accepts pushes.
// - sbe_cnt += scrub_req_valid + rmw_sbe; dbe_cnt += rmw_dbe + rd_dbe.
//   Each may add 2 in one cycle; saturate at all-ones, with no wrap.
//   Requests dropped as duplicate or overflow are still counted.
// - cnt_clr wins over same-cycle increments (result 0). flag_clr wins over same-cycle set.
// - Async reset mid-scrub: all state lost; do_scrub drops immediately.
// - scrub_idle = empty & (state==IDLE).
// STRUCTURE
// - Package nl2_dbank_scrub_pkg:
//   typedef scrub_entry_t {sram_sel, block_addr}.
//   enum scrub_st_t {IDLE, REQ, WAIT}.
//   sat_add(cnt, inc) function.
// - Sub-module nl2_dbank_scrub_fifo:
//   DEPTH-entry storage, wrap pointers, valid bits.
//   Combinational match of incoming entry against all valid entries plus an external
//   in-flight compare.
// - Top-level: FSM, timeout counter, error counters, sticky flags.
// TESTING
// - Single request: sel=4'b0010, addr=0x3A, scrub_en=1, accept same cycle as valid,
//   done 3 cycles later.
//   -> cmd_valid 1 cycle after push, do_scrub high 3 cycles, scrub_idle returns 1,
//   sbe_cnt=1.
// - Dedup: addr 0x10 pushed 3 times (once while in flight).
//   -> exactly one command issued, sbe_cnt=3, ovf_sticky=0.
// - Overflow: scrub_en=0, push 5 distinct addrs with DEPTH=4.
//   -> 5th dropped, ovf_sticky=1.
//   Then scrub_en=1 -> 4 commands in FIFO order.
// - Full push+pop: queue full, in REQ, accept and new distinct push in same cycle.
//   -> push accepted, occupancy stays 4, ovf_sticky=0.
// - Timeout: TIMEOUT_CYC=8, never assert scrub_done.
//   -> after 8 WAIT cycles FSM returns IDLE, tmo_sticky=1, next entry issues.
// - Saturation/clear: CNT_W=4, drive rmw_dbe&rd_dbe for 10 cycles -> dbe_cnt=15.
//   cnt_clr with rd_dbe same cycle -> 0.

Source files
------------

// File: rtl/nl2_dbank_scrub_pkg.sv
// Shared types for the dbank scrub queue: entry bundle, FSM states,
// and a saturating add used by the SBE/DBE event counters.
package nl2_dbank_scrub_pkg;

  localparam int N_SRAM          = 4;
  localparam int BLOCK_ADDR_SIZE = 10;

  typedef struct packed {
    logic [N_SRAM-1:0]          sram_sel;
    logic [BLOCK_ADDR_SIZE-1:0] block_addr;
  } scrub_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } scrub_st_t;

  function automatic logic [31:0] sat_add(
    input logic [31:0] cnt,
    input logic [1:0]  inc,
    input logic [31:0] max
  );
    logic [32:0] sum;
    sum = {1'b0, cnt} + {31'b0, inc};
    if (sum > {1'b0, max}) begin
      return max;
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/nl2_dbank_scrub_fifo.sv
// Dedup queue of pending scrubs: DEPTH slots, wrapping pointers, valid bits.
// Ports: push/din in, pop in, fly_vld/fly in-flight compare, head/empty/ovf out.
module nl2_dbank_scrub_fifo
  import nl2_dbank_scrub_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  scrub_entry_t din,
  input  logic         pop,
  input  logic         fly_vld,
  input  scrub_entry_t fly,
  output scrub_entry_t head,
  output logic         empty,
  output logic         ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  scrub_entry_t     mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             dup;
  logic             full;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    dup = fly_vld && (fly == din);
    for (int i = 0; i < DEPTH; i++) begin
      dup = dup | (vld[i] && (mem[i] == din));
    end
  end

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // a pop in the same cycle frees the slot the push needs
  assign do_push = push & ~dup & (~full | do_pop);
  assign ovf     = push & ~dup & full & ~do_pop;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      vld    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      // pop clears before push sets: on a full push+pop both hit one slot
      if (do_pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + 1'b1;
      end
      if (do_push) begin
        mem[wr_ptr] <= din;
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        cnt <= cnt + CW'(1);
      end else if (do_pop && !do_push) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/nl2_dbank_scrub_queue.sv
// Scrub queue top: issues queued scrubs to the dbank arbiter one at a time,
// holds do_scrub until done/timeout, keeps SBE/DBE counters and sticky flags.
module nl2_dbank_scrub_queue
  import nl2_dbank_scrub_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                       dbank_ctrl_clk,
  input  logic                       rst_a_n,
  input  logic                       scrub_en,
  input  logic                       scrub_req_valid,
  input  logic [N_SRAM-1:0]          scrub_req_sram_sel,
  input  logic [BLOCK_ADDR_SIZE-1:0] scrub_req_block_addr,
  input  logic                       rmw_sbe,
  input  logic                       rmw_dbe,
  input  logic                       rd_dbe,
  output logic                       scrub_cmd_valid,
  input  logic                       scrub_cmd_accept,
  output logic [N_SRAM-1:0]          scrub_cmd_sram_sel,
  output logic [BLOCK_ADDR_SIZE-1:0] scrub_cmd_block_addr,
  input  logic                       scrub_done,
  output logic                       do_scrub,
  output logic [CNT_W-1:0]           sbe_cnt,
  output logic [CNT_W-1:0]           dbe_cnt,
  input  logic                       cnt_clr,
  output logic                       ovf_sticky,
  output logic                       tmo_sticky,
  input  logic                       flag_clr,
  output logic                       scrub_idle
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [31:0] CMAX = {{(32-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  scrub_st_t    st;
  scrub_st_t    st_nxt;
  scrub_entry_t req;
  scrub_entry_t head;
  scrub_entry_t fly;
  logic         empty;
  logic         ovf;
  logic         pop;
  logic         tmo_hit;
  logic [TW-1:0] tmo_cnt;
  logic [31:0]  sbe_sum;
  logic [31:0]  dbe_sum;

  assign req.sram_sel   = scrub_req_sram_sel;
  assign req.block_addr = scrub_req_block_addr;

  nl2_dbank_scrub_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (dbank_ctrl_clk),
    .rst_n   (rst_a_n),
    .push    (scrub_req_valid),
    .din     (req),
    .pop     (pop),
    .fly_vld (st == WAIT),
    .fly     (fly),
    .head    (head),
    .empty   (empty),
    .ovf     (ovf)
  );

  assign tmo_hit = (TIMEOUT_CYC != 0) && (st == WAIT) && !scrub_done &&
                   (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    st_nxt = st;
    pop    = 1'b0;
    unique case (st)
      IDLE: begin
        if (!empty && scrub_en) st_nxt = REQ;
      end
      REQ: begin
        if (scrub_cmd_accept) begin
          st_nxt = WAIT;
          pop    = 1'b1;
        end
      end
      WAIT: begin
        if (scrub_done || tmo_hit) st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  assign scrub_cmd_valid      = (st == REQ);
  assign scrub_cmd_sram_sel   = head.sram_sel;
  assign scrub_cmd_block_addr = head.block_addr;
  assign do_scrub             = (st == WAIT);
  assign scrub_idle           = empty && (st == IDLE);

  assign sbe_sum = sat_add({{(32-CNT_W){1'b0}}, sbe_cnt},
                           {1'b0, scrub_req_valid} + {1'b0, rmw_sbe}, CMAX);
  assign dbe_sum = sat_add({{(32-CNT_W){1'b0}}, dbe_cnt},
                           {1'b0, rmw_dbe} + {1'b0, rd_dbe}, CMAX);

  always_ff @(posedge dbank_ctrl_clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      st         <= IDLE;
      fly        <= '0;
      tmo_cnt    <= '0;
      sbe_cnt    <= '0;
      dbe_cnt    <= '0;
      ovf_sticky <= 1'b0;
      tmo_sticky <= 1'b0;
    end else begin
      st <= st_nxt;
      if (pop) fly <= head;
      tmo_cnt <= (st == WAIT) ? tmo_cnt + 1'b1 : '0;
      sbe_cnt <= cnt_clr ? '0 : sbe_sum[CNT_W-1:0];
      dbe_cnt <= cnt_clr ? '0 : dbe_sum[CNT_W-1:0];
      ovf_sticky <= flag_clr ? 1'b0 : (ovf_sticky | ovf);
      tmo_sticky <= flag_clr ? 1'b0 : (tmo_sticky | tmo_hit);
    end
  end

endmodule

// File: tb/tb_nl2_dbank_scrub_queue.sv
// Directed bench for nl2_dbank_scrub_queue (DEPTH=4, CNT_W=4, TIMEOUT_CYC=8).
// Linear step sequence with immediate-assertion checks.
module tb_nl2_dbank_scrub_queue;

  logic       clk;
  logic       rst_n;
  logic       scrub_en;
  logic       req_valid;
  logic [3:0] req_sel;
  logic [9:0] req_addr;
  logic       rmw_sbe;
  logic       rmw_dbe;
  logic       rd_dbe;
  logic       cmd_valid;
  logic       accept;
  logic [3:0] cmd_sel;
  logic [9:0] cmd_addr;
  logic       done;
  logic       do_scrub;
  logic [3:0] sbe_cnt;
  logic [3:0] dbe_cnt;
  logic       cnt_clr;
  logic       ovf_sticky;
  logic       tmo_sticky;
  logic       flag_clr;
  logic       idle;

  int total = 0;
  int bad   = 0;

  nl2_dbank_scrub_queue #(
    .DEPTH       (4),
    .CNT_W       (4),
    .TIMEOUT_CYC (8)
  ) dut (
    .dbank_ctrl_clk       (clk),
    .rst_a_n              (rst_n),
    .scrub_en             (scrub_en),
    .scrub_req_valid      (req_valid),
    .scrub_req_sram_sel   (req_sel),
    .scrub_req_block_addr (req_addr),
    .rmw_sbe              (rmw_sbe),
    .rmw_dbe              (rmw_dbe),
    .rd_dbe               (rd_dbe),
    .scrub_cmd_valid      (cmd_valid),
    .scrub_cmd_accept     (accept),
    .scrub_cmd_sram_sel   (cmd_sel),
    .scrub_cmd_block_addr (cmd_addr),
    .scrub_done           (done),
    .do_scrub             (do_scrub),
    .sbe_cnt              (sbe_cnt),
    .dbe_cnt              (dbe_cnt),
    .cnt_clr              (cnt_clr),
    .ovf_sticky           (ovf_sticky),
    .tmo_sticky           (tmo_sticky),
    .flag_clr             (flag_clr),
    .scrub_idle           (idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] s, input logic [9:0] a);
    req_valid = 1'b1;
    req_sel   = s;
    req_addr  = a;
  endtask

  // Entered just after the edge into REQ; issues n commands in order.
  task automatic drain(input logic [3:0] s, input int base, input int n);
    for (int i = 0; i < n; i++) begin
      chk("drain_valid", cmd_valid, 1);
      chk("drain_addr", cmd_addr, base + i);
      chk("drain_sel", cmd_sel, s);
      step();
      chk("drain_busy", do_scrub, 1);
      done = 1'b1;
      step();
      done = 1'b0;
      step();
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    scrub_en  = 1'b0;
    req_valid = 1'b0;
    req_sel   = '0;
    req_addr  = '0;
    rmw_sbe   = 1'b0;
    rmw_dbe   = 1'b0;
    rd_dbe    = 1'b0;
    accept    = 1'b0;
    done      = 1'b0;
    cnt_clr   = 1'b0;
    flag_clr  = 1'b0;
    #12;
    chk("rst_valid", cmd_valid, 0);
    chk("rst_busy", do_scrub, 0);
    chk("rst_idle", idle, 1);
    chk("rst_sbe", sbe_cnt, 0);
    chk("rst_dbe", dbe_cnt, 0);
    chk("rst_ovf", ovf_sticky, 0);
    chk("rst_tmo", tmo_sticky, 0);
    rst_n = 1'b1;
    step();

    // single request
    scrub_en = 1'b1;
    push(4'b0010, 10'h3A);
    step();
    chk("s1_novalid", cmd_valid, 0);
    chk("s1_notidle", idle, 0);
    req_valid = 1'b0;
    accept    = 1'b1;
    step();
    chk("s1_valid", cmd_valid, 1);
    chk("s1_sel", cmd_sel, 4'b0010);
    chk("s1_addr", cmd_addr, 10'h3A);
    step();
    accept = 1'b0;
    chk("s1_busy0", do_scrub, 1);
    chk("s1_valid_lo", cmd_valid, 0);
    step();
    chk("s1_busy1", do_scrub, 1);
    step();
    chk("s1_busy2", do_scrub, 1);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("s1_end", do_scrub, 0);
    chk("s1_idle", idle, 1);
    chk("s1_sbe", sbe_cnt, 1);

    // dedup
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr_sbe", sbe_cnt, 0);
    accept = 1'b1;
    push(4'b0001, 10'h10);
    step();
    step();
    chk("d_valid", cmd_valid, 1);
    req_valid = 1'b0;
    step();
    chk("d_busy", do_scrub, 1);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    done = 1'b1;
    step();
    done = 1'b0;
    chk("d_idle0", idle, 1);
    step();
    chk("d_novalid", cmd_valid, 0);
    chk("d_idle1", idle, 1);
    chk("d_sbe", sbe_cnt, 3);
    chk("d_ovf", ovf_sticky, 0);

    // overflow then FIFO order
    cnt_clr  = 1'b1;
    scrub_en = 1'b0;
    accept   = 1'b0;
    step();
    cnt_clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(4'b0100, 10'(32'h100 + i));
      step();
    end
    chk("o_ovf0", ovf_sticky, 0);
    push(4'b0100, 10'h104);
    step();
    req_valid = 1'b0;
    chk("o_ovf1", ovf_sticky, 1);
    chk("o_hold", cmd_valid, 0);
    chk("o_sbe", sbe_cnt, 5);
    scrub_en = 1'b1;
    accept   = 1'b1;
    step();
    drain(4'b0100, 'h100, 4);
    chk("o_idle", idle, 1);
    chk("o_novalid", cmd_valid, 0);

    // full push + pop
    flag_clr = 1'b1;
    scrub_en = 1'b0;
    accept   = 1'b0;
    step();
    flag_clr = 1'b0;
    chk("f_clr", ovf_sticky, 0);
    for (int i = 0; i < 4; i++) begin
      push(4'b1000, 10'(32'h200 + i));
      step();
    end
    req_valid = 1'b0;
    scrub_en  = 1'b1;
    step();
    chk("f_req", cmd_valid, 1);
    chk("f_head", cmd_addr, 10'h200);
    accept = 1'b1;
    push(4'b1000, 10'h204);
    step();
    chk("f_ovf0", ovf_sticky, 0);
    chk("f_busy", do_scrub, 1);
    push(4'b1000, 10'h205);
    step();
    req_valid = 1'b0;
    chk("f_ovf1", ovf_sticky, 1);
    done = 1'b1;
    step();
    done = 1'b0;
    step();
    drain(4'b1000, 'h201, 4);
    chk("f_idle", idle, 1);

    // timeout
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    push(4'b0001, 10'h300);
    step();
    push(4'b0001, 10'h301);
    step();
    req_valid = 1'b0;
    chk("t_addr0", cmd_addr, 10'h300);
    step();
    for (int i = 0; i < 7; i++) begin
      chk("t_wait", do_scrub, 1);
      step();
    end
    chk("t_wait7", do_scrub, 1);
    chk("t_tmo0", tmo_sticky, 0);
    step();
    chk("t_abort", do_scrub, 0);
    chk("t_tmo1", tmo_sticky, 1);
    step();
    chk("t_next", cmd_valid, 1);
    chk("t_addr1", cmd_addr, 10'h301);
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    chk("t_idle", idle, 1);
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    chk("t_clr", tmo_sticky, 0);

    // saturation / clear
    rmw_dbe = 1'b1;
    rd_dbe  = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("c_dbe6", dbe_cnt, 6);
    for (int i = 0; i < 7; i++) step();
    chk("c_sat", dbe_cnt, 15);
    rmw_dbe = 1'b0;
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    rd_dbe  = 1'b0;
    chk("c_clr", dbe_cnt, 0);

    // async reset mid-scrub
    push(4'b0010, 10'h3F0);
    step();
    req_valid = 1'b0;
    step();
    step();
    chk("r_busy", do_scrub, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r_drop", do_scrub, 0);
    chk("r_idle", idle, 1);
    chk("r_sbe", sbe_cnt, 0);
    #2;
    rst_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
